// File: rtl/serial_add_sub_if.sv
// rtl/serial_add_sub_if.sv - operand/result handshake bundle for serial_add_sub
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );
endinterface

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial adder/subtractor, LSB first, one bit per clock
// Optional feature macro: SERIAL_ADD_SUB_OVERFLOW_EN (signed overflow output)
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_sub_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             sum_bit;
  logic             carry_next;
  logic             in_ready_c;
  logic             out_valid_c;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
  logic             msb_cin_q, msb_cin_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
      msb_cin_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
      msb_cin_q <= msb_cin_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    cout_d      = cout_q;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    msb_cin_d   = msb_cin_q;
`endif
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    sum_bit     = sa_q[0] ^ sb_q[0] ^ c_q;
    carry_next  = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);

    case (state_q)
      IDLE: begin
        in_ready_c = ~rst;
        if (bus.in_valid) begin
          // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
          sa_d    = bus.a;
          sb_d    = bus.sub ? ~bus.b : bus.b;
          c_d     = bus.sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        c_d   = carry_next;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = {sum_bit, res_q[WIDTH-1:1]};
        if (cnt_q == LAST) begin
          cout_d  = carry_next;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
          msb_cin_d = c_q;
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        out_valid_c = ~rst;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = res_q;
  assign bus.carry_out = cout_q;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
  assign bus.overflow  = msb_cin_q ^ cout_q;
`else
  assign bus.overflow  = 1'b0;
`endif
endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - randomized and directed bench for serial_add_sub with arithmetic reference model
module tb_serial_add_sub;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  serial_add_sub_if #(.WIDTH(W)) bus ();

  serial_add_sub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer and signed arithmetic.
  function automatic void ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                 output logic [W-1:0] r, output logic c, output logic o);
    int xi, yi, sx, sy, sr, full;
    xi = int'(x);
    yi = int'(y);
    sx = (xi >= 128) ? xi - 256 : xi;
    sy = (yi >= 128) ? yi - 256 : yi;
    if (!s) begin
      full = xi + yi;
      c    = (full >= 256);
      sr   = sx + sy;
    end else begin
      full = xi - yi;
      c    = (xi >= yi);
      sr   = sx - sy;
    end
    r = full[W-1:0];
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    o = (sr > 127) || (sr < -128);
`else
    o = 1'b0;
`endif
  endfunction

  // Model of the handshake timing: busy from accept until retire.
  int         cyc = 0;
  bit         m_busy = 1'b0;
  int         m_acc = 0;
  logic [W-1:0] m_res = '0;
  logic       m_c = 1'b0;
  logic       m_o = 1'b0;
  bit         b2b = 1'b0;
  int         last_acc = -1;
  int         n_acc = 0;

  always @(posedge clk) begin
    bit was_busy;
    cyc++;
    was_busy = m_busy;
    if (rst) begin
      m_busy = 1'b0;
    end else begin
      if (m_busy && bus.out_ready && (cyc - m_acc >= W + 1)) m_busy = 1'b0;
      if (!was_busy && bus.in_valid) begin
        m_busy = 1'b1;
        m_acc  = cyc;
        ref_op(bus.a, bus.b, bus.sub, m_res, m_c, m_o);
        if (b2b && last_acc >= 0) chk("b2b_spacing", cyc - last_acc, W + 2);
        last_acc = cyc;
        n_acc++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_valid;
      exp_valid = m_busy && (cyc - m_acc >= W) && !rst;
      chk("in_ready", bus.in_ready, !m_busy && !rst);
      chk("out_valid", bus.out_valid, exp_valid);
      if (bus.out_valid && exp_valid) begin
        chk("model_result", bus.result, m_res);
        chk("model_carry", bus.carry_out, m_c);
        chk("model_ovf", bus.overflow, m_o);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      step();
      n++;
    end
    if (!bus.in_ready) chk("wait_ready_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 60) begin
      step();
      lat++;
    end
    if (!bus.out_valid) chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    wait_ready();
    bus.a = x;
    bus.b = y;
    bus.sub = s;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic op_lit(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input logic [W-1:0] er, input logic ec, input logic eo, input string nm);
    int lat;
    logic eov;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    eov = eo;
`else
    eov = 1'b0;
`endif
    launch(x, y, s);
    wait_valid(lat);
    chk({nm, "_latency"}, lat, W);
    chk({nm, "_result"}, bus.result, er);
    chk({nm, "_carry"}, bus.carry_out, ec);
    chk({nm, "_ovf"}, bus.overflow, eov);
    retire();
  endtask

  initial begin
    logic [W-1:0] pr;
    logic pc, po;
    int lat, n0;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sub = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_carry", bus.carry_out, 0);
    chk("rst_ovf", bus.overflow, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk_en = 1'b1;

    // Pin the reference model with hand-computed values.
    ref_op(8'h35, 8'h4A, 1'b0, pr, pc, po);
    chk("pin_add", {pc, pr}, {1'b0, 8'h7F});
    ref_op(8'h00, 8'h01, 1'b1, pr, pc, po);
    chk("pin_sub_borrow", {pc, pr}, {1'b0, 8'hFF});
    ref_op(8'hFF, 8'h01, 1'b0, pr, pc, po);
    chk("pin_add_carry", {pc, pr}, {1'b1, 8'h00});
    ref_op(8'h80, 8'h01, 1'b1, pr, pc, po);
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    chk("pin_sub_ovf", po, 1);
`else
    chk("pin_sub_ovf", po, 0);
`endif

    op_lit(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "add_35_4a");
    op_lit(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
    op_lit(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    op_lit(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0, "sub_10_01");
    op_lit(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, "sub_00_01");
    op_lit(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");

    // Backpressure: result held, new operands ignored while DONE.
    launch(8'h35, 8'h4A, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      bus.in_valid = 1'b1;
      chk("bp_result_hold", bus.result, 8'h7F);
      chk("bp_in_ready", bus.in_ready, 0);
      step();
    end
    bus.a = 8'h01;
    bus.b = 8'h02;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_release_in_ready", bus.in_ready, 1);
    chk("bp_release_out_valid", bus.out_valid, 0);
    step();
    bus.in_valid = 1'b0;
    chk("bp_accepted", bus.in_ready, 0);
    wait_valid(lat);
    chk("bp_next_result", bus.result, 8'h03);
    retire();

    // Reset in the middle of a run.
    launch(8'h55, 8'h22, 1'b0);
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_result", bus.result, 0);
    chk("midrst_carry", bus.carry_out, 0);
    chk("midrst_ovf", bus.overflow, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("midrst_idle", bus.in_ready, 1);
    op_lit(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "post_rst_add");

    // Random operations with random consumer delay.
    for (int i = 0; i < 30; i++) begin
      launch(8'($urandom), 8'($urandom), 1'($urandom));
      wait_valid(lat);
      repeat ($urandom_range(0, 3)) step();
      retire();
    end

    // Back-to-back with both handshakes held high.
    b2b = 1'b1;
    last_acc = -1;
    n0 = n_acc;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5 * (W + 2) + 1; i++) begin
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      bus.sub = 1'($urandom);
      step();
    end
    bus.in_valid = 1'b0;
    chk("b2b_accepts", n_acc - n0, 6);
    repeat (W + 3) step();
    bus.out_ready = 1'b0;
    b2b = 1'b0;
    step();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
